jam_ctrl_unit: RTL and testbench

// - Initiator side of the jam-operation interface: detects per-lane traffic jams from queue lengths
//   and sequences the jam-serving unit via jam_op_en / jam_start / jam_rotation.
// - Times each lane's jam green window and watches the returned allow_*_jam grants for protocol errors.
// - Sits between the lane queue counters and the jam-serving unit in the traffic controller top level.

---
 rtl/jam_pkg.sv | 44 ++++
 rtl/jam_ctrl_unit_if.sv | 29 ++
 rtl/jam_detect.sv | 52 +++++
 rtl/jam_ctrl_unit.sv | 157 +++++++++++++++
 tb/tb_jam_ctrl_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jam_pkg.sv
`default_nettype none
// =====================================================================
// Package : jam_pkg
// Shared types and default thresholds for the jam controller and the
// jam-serving unit.
// Revision: 1.0 - initial release
// =====================================================================
package jam_pkg;

   localparam int NUM_LANES      = 4;
   localparam int LANE_W         = $clog2(NUM_LANES);

   localparam int JAM_CNT_W      = 8;
   localparam int JAM_ON_DEF     = 20;
   localparam int JAM_OFF_DEF    = 8;
   localparam int DEBOUNCE_DEF   = 4;
   localparam int GREEN_CYC_DEF  = 64;
   localparam int MIN_GREEN_DEF  = 16;
   localparam int HOLDOFF_DEF    = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_SERVE  = 3'd2,
      ST_ROTATE = 3'd3,
      ST_DRAIN  = 3'd4
   } jam_state_e;

   function automatic logic is_onehot(input logic [NUM_LANES-1:0] v);
      return (v != '0) && ((v & (v - NUM_LANES'(1))) == '0);
   endfunction

   // Index of the lowest set bit; only meaningful when v is one-hot.
   function automatic logic [LANE_W-1:0] onehot_idx(input logic [NUM_LANES-1:0] v);
      logic [LANE_W-1:0] idx;
      idx = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (v[i]) idx = LANE_W'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jam_ctrl_unit_if.sv
`default_nettype none
// =====================================================================
// Interface : jam_ctrl_unit_if
// Session control from the controller and grant feedback from the
// jam-serving unit.
// Revision: 1.0 - initial release
// =====================================================================
interface jam_ctrl_unit_if;

   logic jam_op_en;
   logic jam_start;
   logic jam_rotation;
   logic allow_0_jam;
   logic allow_1_jam;
   logic allow_2_jam;
   logic allow_3_jam;

   modport master (
      output jam_op_en, jam_start, jam_rotation,
      input  allow_0_jam, allow_1_jam, allow_2_jam, allow_3_jam
   );

   modport slave (
      input  jam_op_en, jam_start, jam_rotation,
      output allow_0_jam, allow_1_jam, allow_2_jam, allow_3_jam
   );

endinterface
`default_nettype wire

// File: rtl/jam_detect.sv
`default_nettype none
// =====================================================================
// Module : jam_detect
// Per-lane jam flag: debounced set at JAM_ON, hysteretic clear at JAM_OFF.
// Revision: 1.0 - initial release
// =====================================================================
module jam_detect #(
   parameter int CNT_W    = 8,
   parameter int JAM_ON   = 20,
   parameter int JAM_OFF  = 8,
   parameter int DEBOUNCE = 4
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic [CNT_W-1:0] q_len,
   output logic                  traffic_jam
);

   localparam int              DEB_W   = $clog2(DEBOUNCE + 1);
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE);

   logic [DEB_W-1:0] deb_q, deb_d;
   logic             jam_q, jam_d;

   always_comb begin
      deb_d = '0;
      jam_d = jam_q;
      if (q_len >= CNT_W'(JAM_ON)) begin
         deb_d = (deb_q == DEB_MAX) ? deb_q : deb_q + DEB_W'(1);
      end
      // Between the thresholds the flag simply holds.
      if (deb_d == DEB_MAX) begin
         jam_d = 1'b1;
      end else if (q_len <= CNT_W'(JAM_OFF)) begin
         jam_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q <= '0;
         jam_q <= 1'b0;
      end else begin
         deb_q <= deb_d;
         jam_q <= jam_d;
      end
   end

   assign traffic_jam = jam_q;

endmodule
`default_nettype wire

// File: rtl/jam_ctrl_unit.sv
`default_nettype none
// =====================================================================
// Module : jam_ctrl_unit
// Jam session sequencer: lane detection, green-window timing, holdoff
// and grant protocol checking toward the jam-serving unit.
// Revision: 1.0 - initial release
// =====================================================================
module jam_ctrl_unit
   import jam_pkg::*;
#(
   parameter int CNT_W     = JAM_CNT_W,
   parameter int JAM_ON    = JAM_ON_DEF,
   parameter int JAM_OFF   = JAM_OFF_DEF,
   parameter int DEBOUNCE  = DEBOUNCE_DEF,
   parameter int GREEN_CYC = GREEN_CYC_DEF,
   parameter int MIN_GREEN = MIN_GREEN_DEF,
   parameter int HOLDOFF   = HOLDOFF_DEF
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              sys_jam_en,
   input  wire logic [CNT_W-1:0]  q_len_0,
   input  wire logic [CNT_W-1:0]  q_len_1,
   input  wire logic [CNT_W-1:0]  q_len_2,
   input  wire logic [CNT_W-1:0]  q_len_3,
   jam_ctrl_unit_if.master        jam_if,
   output logic                   traffic_jam_0,
   output logic                   traffic_jam_1,
   output logic                   traffic_jam_2,
   output logic                   traffic_jam_3,
   output logic                   grant_err
);

   localparam int TMR_W = $clog2(GREEN_CYC + 1);
   localparam int HLD_W = $clog2(HOLDOFF + 1);

   logic [CNT_W-1:0]     q_len_a [NUM_LANES];
   logic [NUM_LANES-1:0] tj;
   logic [NUM_LANES-1:0] allow;

   assign q_len_a[0] = q_len_0;
   assign q_len_a[1] = q_len_1;
   assign q_len_a[2] = q_len_2;
   assign q_len_a[3] = q_len_3;

   generate
      for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
         jam_detect #(
            .CNT_W    (CNT_W),
            .JAM_ON   (JAM_ON),
            .JAM_OFF  (JAM_OFF),
            .DEBOUNCE (DEBOUNCE)
         ) u_detect (
            .clk         (clk),
            .rst_n       (rst_n),
            .q_len       (q_len_a[i]),
            .traffic_jam (tj[i])
         );
      end
   endgenerate

   assign allow = {jam_if.allow_3_jam, jam_if.allow_2_jam,
                   jam_if.allow_1_jam, jam_if.allow_0_jam};

   jam_state_e       state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [HLD_W-1:0] hold_q, hold_d;
   logic             grant_err_q, grant_err_d;

   logic             grant_valid;
   logic             any_jam;
   logic             jam_g;
   logic             others_jam;

   always_comb begin
      grant_valid = is_onehot(allow);
      any_jam     = |tj;
      jam_g       = tj[onehot_idx(allow)];
      // Without a valid grant every jammed lane counts as "another" lane.
      others_jam  = grant_valid ? |(tj & ~allow) : any_jam;
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      hold_d      = hold_q;
      grant_err_d = grant_err_q;

      case (state_q)
         ST_IDLE: begin
            if (sys_jam_en && any_jam) state_d = ST_START;
         end
         ST_START, ST_ROTATE: begin
            if (!sys_jam_en) begin
               state_d = ST_DRAIN;
               hold_d  = '0;
            end else begin
               state_d = ST_SERVE;
               timer_d = '0;
            end
         end
         ST_SERVE: begin
            if (!grant_valid) grant_err_d = 1'b1;
            if (!sys_jam_en || !any_jam) begin
               state_d = ST_DRAIN;
               hold_d  = '0;
            end else if (grant_valid && (timer_q >= TMR_W'(MIN_GREEN - 1)) && !jam_g) begin
               state_d = ST_ROTATE;
            end else if (timer_q == TMR_W'(GREEN_CYC - 1)) begin
               // A lone jammed lane keeps its green; the window just restarts.
               if (others_jam) state_d = ST_ROTATE;
               else            timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_DRAIN: begin
            if (hold_q == HLD_W'(HOLDOFF - 1)) begin
               state_d = ST_IDLE;
               hold_d  = '0;
            end else begin
               hold_d  = hold_q + HLD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         hold_q      <= '0;
         grant_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         hold_q      <= hold_d;
         grant_err_q <= grant_err_d;
      end
   end

   assign jam_if.jam_start    = (state_q == ST_START);
   assign jam_if.jam_rotation = (state_q == ST_ROTATE);
   assign jam_if.jam_op_en    = (state_q == ST_START) || (state_q == ST_SERVE) ||
                                (state_q == ST_ROTATE);

   assign grant_err     = grant_err_q;
   assign traffic_jam_0 = tj[0];
   assign traffic_jam_1 = tj[1];
   assign traffic_jam_2 = tj[2];
   assign traffic_jam_3 = tj[3];

endmodule
`default_nettype wire

// File: tb/tb_jam_ctrl_unit.sv
`default_nettype none
// =====================================================================
// Module : tb_jam_ctrl_unit
// Directed scoreboard bench for jam_ctrl_unit with a jam-serving unit model.
// Revision: 1.0 - initial release
// =====================================================================
module tb_jam_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sys_jam_en = 1'b0;
   logic [7:0] q0 = '0, q1 = '0, q2 = '0, q3 = '0;
   logic       tj0, tj1, tj2, tj3, grant_err;
   logic [3:0] grant_q;
   logic [3:0] force_bits = '0;
   logic [3:0] w_allow;

   jam_ctrl_unit_if jif ();

   assign w_allow         = (jif.jam_op_en ? grant_q : 4'b0000) | force_bits;
   assign jif.allow_0_jam = w_allow[0];
   assign jif.allow_1_jam = w_allow[1];
   assign jif.allow_2_jam = w_allow[2];
   assign jif.allow_3_jam = w_allow[3];

   jam_ctrl_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sys_jam_en    (sys_jam_en),
      .q_len_0       (q0),
      .q_len_1       (q1),
      .q_len_2       (q2),
      .q_len_3       (q3),
      .jam_if        (jif),
      .traffic_jam_0 (tj0),
      .traffic_jam_1 (tj1),
      .traffic_jam_2 (tj2),
      .traffic_jam_3 (tj3),
      .grant_err     (grant_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Serving unit: first jammed lane on start, next jammed lane on rotation.
   function automatic logic [3:0] pick_next(input logic [3:0] jams, input int cur);
      for (int k = 1; k <= 4; k++) begin
         if (jams[(cur + k) % 4]) return 4'b0001 << ((cur + k) % 4);
      end
      return 4'b0000;
   endfunction

   function automatic int idx_of(input logic [3:0] g);
      for (int k = 0; k < 4; k++) if (g[k]) return k;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                grant_q <= 4'b0000;
      else if (!jif.jam_op_en)   grant_q <= 4'b0000;
      else if (jif.jam_start)    grant_q <= pick_next({tj3, tj2, tj1, tj0}, 3);
      else if (jif.jam_rotation) grant_q <= pick_next({tj3, tj2, tj1, tj0}, idx_of(grant_q));
   end

   logic [11:0] vec;
   assign vec = {grant_err, jif.jam_rotation, jif.jam_start, jif.jam_op_en,
                 w_allow, tj3, tj2, tj1, tj0};

   typedef struct {
      int          cyc;
      logic [11:0] v;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        m_e;
   int          n_checks = 0;
   int          n_err = 0;
   int          base = 0;
   bit          mon_en = 1'b0;
   logic [11:0] prev = '0;

   task automatic expect_ev(input int off, input logic [11:0] v);
      exp_t e;
      e.cyc = base + off;
      e.v   = v;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Every change of the observed output vector must match the next expected event.
   always begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
         prev = vec;
      end else if (vec !== prev) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: cyc=%0d vec=%h", cyc - base, vec);
         end else begin
            m_e = exp_q.pop_front();
            if (m_e.cyc != cyc || m_e.v !== vec) begin
               n_err++;
               $display("FAIL event: got cyc=%0d vec=%h, expected cyc=%0d vec=%h",
                        cyc - base, vec, m_e.cyc - base, m_e.v);
            end
         end
         prev = vec;
      end
   end

   task automatic phase_begin(input string name, input logic en,
                              input logic [7:0] a, b, c, d);
      @(negedge clk);
      mon_en     = 1'b0;
      rst_n      = 1'b0;
      force_bits = 4'b0000;
      sys_jam_en = en;
      q0 = a; q1 = b; q2 = c; q3 = d;
      #1;
      check({name, "_reset_state"}, 32'(vec), 32'h0);
      repeat (2) @(negedge clk);
      check({name, "_held_in_reset"}, 32'(vec), 32'h0);
      rst_n = 1'b1;
      base  = cyc;
   endtask

   task automatic at_cyc(input int off);
      while (cyc < base + off) @(negedge clk);
   endtask

   task automatic phase_end(input string name, input int off);
      at_cyc(off);
      #2;
      check({name, "_pending_events"}, 32'(exp_q.size()), 32'h0);
      exp_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Detection, debounce and hysteresis with sessions disabled.
      phase_begin("detect", 1'b0, 8'd30, 8'd30, 8'd30, 8'd30);
      expect_ev(4,  12'h00F);
      expect_ev(32, 12'h00E);
      mon_en = 1'b1;
      at_cyc(10);
      q0 = 8'd15; q1 = 8'd15; q2 = 8'd15; q3 = 8'd15;
      for (int k = 11; k <= 30; k++) begin
         at_cyc(k);
         q0 = 8'(10 + k % 10); q1 = 8'(10 + k % 10);
         q2 = 8'(10 + k % 10); q3 = 8'(10 + k % 10);
      end
      at_cyc(31);
      q0 = 8'd5; q1 = 8'd19; q2 = 8'd19; q3 = 8'd19;
      at_cyc(33);
      q0 = 8'd19;
      phase_end("detect", 140);

      // Session start, abort, drain holdoff with a reappearing jam.
      phase_begin("session", 1'b1, 8'd0, 8'd25, 8'd0, 8'd0);
      expect_ev(4,  12'h002);
      expect_ev(5,  12'h302);
      expect_ev(6,  12'h122);
      expect_ev(21, 12'h002);
      expect_ev(41, 12'h302);
      expect_ev(42, 12'h122);
      expect_ev(51, 12'h120);
      expect_ev(52, 12'h000);
      expect_ev(57, 12'h002);
      expect_ev(61, 12'h302);
      expect_ev(62, 12'h122);
      mon_en = 1'b1;
      at_cyc(20); sys_jam_en = 1'b0;
      at_cyc(40); sys_jam_en = 1'b1;
      at_cyc(50); q1 = 8'd0;
      at_cyc(53); q1 = 8'd25;
      phase_end("session", 70);

      // Max-green rotation between lanes 0 and 2, then lane 0 alone.
      phase_begin("maxgreen", 1'b1, 8'd30, 8'd0, 8'd30, 8'd0);
      expect_ev(4,   12'h005);
      expect_ev(5,   12'h305);
      expect_ev(6,   12'h115);
      expect_ev(70,  12'h515);
      expect_ev(71,  12'h145);
      expect_ev(135, 12'h545);
      expect_ev(136, 12'h115);
      expect_ev(141, 12'h111);
      mon_en = 1'b1;
      at_cyc(140); q2 = 8'd0;
      phase_end("maxgreen", 345);

      // Early rotation at MIN_GREEN-1 after lane 0 clears, then drain.
      phase_begin("early", 1'b1, 8'd30, 8'd0, 8'd30, 8'd0);
      expect_ev(4,  12'h005);
      expect_ev(5,  12'h305);
      expect_ev(6,  12'h115);
      expect_ev(10, 12'h114);
      expect_ev(22, 12'h514);
      expect_ev(23, 12'h144);
      expect_ev(31, 12'h140);
      expect_ev(32, 12'h000);
      mon_en = 1'b1;
      at_cyc(9);  q0 = 8'd5;
      at_cyc(30); q2 = 8'd0;
      phase_end("early", 50);

      // Illegal grant pattern sets the sticky error.
      phase_begin("granterr", 1'b1, 8'd0, 8'd25, 8'd0, 8'd0);
      expect_ev(4,  12'h002);
      expect_ev(5,  12'h302);
      expect_ev(6,  12'h122);
      expect_ev(10, 12'h1B2);
      expect_ev(11, 12'h9B2);
      expect_ev(12, 12'h922);
      expect_ev(15, 12'h802);
      mon_en = 1'b1;
      at_cyc(10); force_bits = 4'b1001;
      at_cyc(12); force_bits = 4'b0000;
      at_cyc(14); sys_jam_en = 1'b0;
      phase_end("granterr", 30);
      check("grant_err_sticky", 32'(grant_err), 32'h1);

      @(negedge clk);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("grant_err_cleared_by_reset", 32'(grant_err), 32'h0);
      check("final_reset_state", 32'(vec), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
